// File: rtl/dual_ram_param_if.sv
// Bus bundle for dual_ram_param: write port, read port, clear request and status.
// The design drives only rd_data, rd_valid and init_busy.
interface dual_ram_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                    clr_req;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    init_busy;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/dual_ram_param.sv
// Simple dual-port RAM with byte-enabled writes, write-first reads, optional
// output register and a sequencer that zeroes every word after reset or on request.
module dual_ram_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int OUT_REG    = 0
) (
  input logic           clk,
  input logic           rst,
  dual_ram_param_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_data_s;
  logic [BYTES-1:0]      mem_be_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic                  s1_valid_r, s2_valid_r, rd_valid_r, init_busy_r;
  logic [DATA_WIDTH-1:0] s1_data_r, s2_data_r, rd_data_r;
  logic                  last_valid_s;
  logic [DATA_WIDTH-1:0] last_data_s;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      else       res[8*i +: 8] = old_word[8*i +: 8];
    end
    return res;
  endfunction

  // State and clear-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state and memory write-port selection (clear sequencer owns the port in CLEAR)
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    mem_we_s   = 1'b0;
    mem_addr_s = bus.wr_addr;
    mem_data_s = bus.wr_data;
    mem_be_s   = bus.wr_be;
    rd_acc_s   = 1'b0;
    case (state_r)
      CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = cnt_r;
        mem_data_s = {DATA_WIDTH{1'b0}};
        mem_be_s   = {BYTES{1'b1}};
        if (bus.clr_req) begin
          cnt_s = {ADDR_WIDTH{1'b0}};
        end else if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
          cnt_s   = {ADDR_WIDTH{1'b0}};
          state_s = READY;
        end else begin
          cnt_s = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      READY: begin
        mem_we_s = bus.wr_en;
        rd_acc_s = bus.rd_en;
        if (bus.clr_req) begin
          state_s = CLEAR;
          cnt_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s = READY;
        end
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Write-first read: bytes being written this cycle bypass the array
  always_comb begin
    rd_word_s = mem_r[bus.rd_addr];
    if (state_r == READY && bus.wr_en && bus.wr_addr == bus.rd_addr) begin
      rd_word_s = byte_merge(mem_r[bus.rd_addr], bus.wr_data, bus.wr_be);
    end else begin
      rd_word_s = mem_r[bus.rd_addr];
    end
  end

  // Memory array, intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= byte_merge(mem_r[mem_addr_s], mem_data_s, mem_be_s);
    end
  end

  // Choose the stage that feeds the output register
  always_comb begin
    last_valid_s = s1_valid_r;
    last_data_s  = s1_data_r;
    if (OUT_REG != 0) begin
      last_valid_s = s2_valid_r;
      last_data_s  = s2_data_r;
    end else begin
      last_valid_s = s1_valid_r;
      last_data_s  = s1_data_r;
    end
  end

  // Read pipeline and registered outputs; data registers only load on a valid read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= {DATA_WIDTH{1'b0}};
      s2_valid_r  <= 1'b0;
      s2_data_r   <= {DATA_WIDTH{1'b0}};
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      s1_valid_r  <= rd_acc_s;
      if (rd_acc_s) s1_data_r <= rd_word_s;
      s2_valid_r  <= s1_valid_r;
      if (s1_valid_r) s2_data_r <= s1_data_r;
      rd_valid_r  <= last_valid_s;
      if (last_valid_s) rd_data_r <= last_data_s;
      init_busy_r <= (state_s == CLEAR);
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.init_busy = init_busy_r;
endmodule
